// File: rtl/cci_mpf_shim_edge_afu_wr_heap.sv
// cci_mpf_shim_edge_afu_wr_heap
//
// Write-data heap allocator at the AFU end of the MPF pipeline.
// - Each AFU C1 write packet gets one heap index, taken from a free list.
// - Every data beat is written to the FIU-edge heap RAM at {widx, wclnum}.
// - One header-only request per packet goes into the MPF pipeline. The heap
//   index is carried in place of the line data.
// - The FIU edge returns indices on free_en/free_idx as writes retire.
//
// Ports
//   clk, reset                    clock, synchronous active-high reset
//   afu_c1_*                      AFU write flits in, almfull back to the AFU
//   mpf_c1_*                      header-only requests into MPF, almfull in
//   heap_w*                       FIU-edge heap RAM write port
//   free_en, free_idx             index return from the FIU edge
//   stat_free_cnt, stat_min_free  optional statistics (CCI_MPF_WR_HEAP_STATS_EN)
//
// Optional feature macro: CCI_MPF_WR_HEAP_STATS_EN

module cci_mpf_shim_edge_afu_wr_heap #(
    parameter int N_WRITE_HEAP_ENTRIES = 128,
    parameter int ALMFULL_THRESHOLD    = 8,
    parameter int HDR_W                = 80,
    localparam int IDX_W               = $clog2(N_WRITE_HEAP_ENTRIES)
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              afu_c1_valid,
    input  logic              afu_c1_sop,
    input  logic [1:0]        afu_c1_cl_len,
    input  logic [HDR_W-1:0]  afu_c1_hdr,
    input  logic [511:0]      afu_c1_data,
    output logic              afu_c1_almfull,

    output logic              mpf_c1_valid,
    output logic [HDR_W-1:0]  mpf_c1_hdr,
    output logic [1:0]        mpf_c1_cl_len,
    output logic [IDX_W-1:0]  mpf_c1_idx,
    input  logic              mpf_c1_almfull,

    output logic              heap_wen,
    output logic [IDX_W-1:0]  heap_widx,
    output logic [1:0]        heap_wclnum,
    output logic [511:0]      heap_wdata,

    input  logic              free_en,
    input  logic [IDX_W-1:0]  free_idx
`ifdef CCI_MPF_WR_HEAP_STATS_EN
    ,
    output logic [IDX_W:0]    stat_free_cnt,
    output logic [IDX_W:0]    stat_min_free
`endif
);

    // state | meaning
    // INIT  | seeding the free list with indices 0..N-1, one per cycle
    // RUN   | normal operation; flits accepted, indices popped and returned

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [IDX_W:0]   N_CNT    = (IDX_W+1)'(N_WRITE_HEAP_ENTRIES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WRITE_HEAP_ENTRIES - 1);

    state_t state_q, state_d;

    // Free list: circular buffer, head is always readable (show-ahead).
    // During INIT the write pointer doubles as the seed counter.
    logic [IDX_W-1:0] fifo_q [N_WRITE_HEAP_ENTRIES];
    logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [IDX_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [IDX_W:0]   free_cnt_q, free_cnt_d;
    logic             push;
    logic             pop;
    logic [IDX_W-1:0] push_data;
    logic [IDX_W-1:0] head_idx;

    logic [IDX_W-1:0] cur_idx_q, cur_idx_d;
    logic [1:0]       beats_rem_q, beats_rem_d;
    logic [1:0]       beat_q, beat_d;

    logic             flit_acc;
    logic             sop_acc;

    logic             mpf_valid_q, mpf_valid_d;
    logic [HDR_W-1:0] mpf_hdr_q, mpf_hdr_d;
    logic [1:0]       mpf_cl_len_q, mpf_cl_len_d;
    logic [IDX_W-1:0] mpf_idx_q, mpf_idx_d;

    logic             heap_wen_q, heap_wen_d;
    logic [IDX_W-1:0] heap_widx_q, heap_widx_d;
    logic [1:0]       heap_wclnum_q, heap_wclnum_d;
    logic [511:0]     heap_wdata_q, heap_wdata_d;

    assign head_idx = fifo_q[rd_ptr_q];

    always_comb begin
        state_d   = state_q;
        push      = 1'b0;
        push_data = free_idx;
        unique case (state_q)
            ST_INIT: begin
                push      = 1'b1;
                push_data = wr_ptr_q;
                if (wr_ptr_q == LAST_IDX) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                push = free_en;
            end
            default: state_d = ST_INIT;
        endcase
    end

    assign flit_acc = (state_q == ST_RUN) && afu_c1_valid;
    assign sop_acc  = flit_acc && afu_c1_sop;
    assign pop      = sop_acc;

    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        free_cnt_d = free_cnt_q;
        if (push && !pop) begin
            free_cnt_d = free_cnt_q + 1'b1;
        end else if (pop && !push) begin
            free_cnt_d = free_cnt_q - 1'b1;
        end
    end

    always_comb begin
        cur_idx_d     = cur_idx_q;
        beats_rem_d   = beats_rem_q;
        beat_d        = beat_q;
        mpf_valid_d   = 1'b0;
        mpf_hdr_d     = mpf_hdr_q;
        mpf_cl_len_d  = mpf_cl_len_q;
        mpf_idx_d     = mpf_idx_q;
        heap_wen_d    = 1'b0;
        heap_widx_d   = heap_widx_q;
        heap_wclnum_d = heap_wclnum_q;
        heap_wdata_d  = heap_wdata_q;
        if (flit_acc) begin
            heap_wen_d   = 1'b1;
            heap_wdata_d = afu_c1_data;
            if (afu_c1_sop) begin
                cur_idx_d     = head_idx;
                beats_rem_d   = afu_c1_cl_len;
                beat_d        = 2'd0;
                mpf_valid_d   = 1'b1;
                mpf_hdr_d     = afu_c1_hdr;
                mpf_cl_len_d  = afu_c1_cl_len;
                mpf_idx_d     = head_idx;
                heap_widx_d   = head_idx;
                heap_wclnum_d = 2'd0;
            end else begin
                beats_rem_d   = beats_rem_q - 2'd1;
                beat_d        = beat_q + 2'd1;
                heap_widx_d   = cur_idx_q;
                heap_wclnum_d = beat_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_INIT;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            free_cnt_q    <= '0;
            cur_idx_q     <= '0;
            beats_rem_q   <= '0;
            beat_q        <= '0;
            mpf_valid_q   <= 1'b0;
            mpf_hdr_q     <= '0;
            mpf_cl_len_q  <= '0;
            mpf_idx_q     <= '0;
            heap_wen_q    <= 1'b0;
            heap_widx_q   <= '0;
            heap_wclnum_q <= '0;
            heap_wdata_q  <= '0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            free_cnt_q    <= free_cnt_d;
            cur_idx_q     <= cur_idx_d;
            beats_rem_q   <= beats_rem_d;
            beat_q        <= beat_d;
            mpf_valid_q   <= mpf_valid_d;
            mpf_hdr_q     <= mpf_hdr_d;
            mpf_cl_len_q  <= mpf_cl_len_d;
            mpf_idx_q     <= mpf_idx_d;
            heap_wen_q    <= heap_wen_d;
            heap_widx_q   <= heap_widx_d;
            heap_wclnum_q <= heap_wclnum_d;
            heap_wdata_q  <= heap_wdata_d;
        end
    end

    // Storage has no reset; INIT rewrites every slot before anything is read.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            fifo_q[wr_ptr_q] <= push_data;
        end
    end

    always_comb begin
        if (state_q == ST_INIT) begin
            afu_c1_almfull = 1'b1;
        end else begin
            afu_c1_almfull = mpf_c1_almfull ||
                             (int'(free_cnt_q) <= ALMFULL_THRESHOLD);
        end
    end

    assign mpf_c1_valid  = mpf_valid_q;
    assign mpf_c1_hdr    = mpf_hdr_q;
    assign mpf_c1_cl_len = mpf_cl_len_q;
    assign mpf_c1_idx    = mpf_idx_q;
    assign heap_wen      = heap_wen_q;
    assign heap_widx     = heap_widx_q;
    assign heap_wclnum   = heap_wclnum_q;
    assign heap_wdata    = heap_wdata_q;

`ifdef CCI_MPF_WR_HEAP_STATS_EN
    logic [IDX_W:0] stat_min_free_q, stat_min_free_d;

    always_comb begin
        stat_min_free_d = stat_min_free_q;
        if (state_q == ST_INIT && state_d == ST_RUN) begin
            stat_min_free_d = N_CNT;
        end else if (state_q == ST_RUN && free_cnt_q < stat_min_free_q) begin
            stat_min_free_d = free_cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_min_free_q <= '0;
        end else begin
            stat_min_free_q <= stat_min_free_d;
        end
    end

    assign stat_free_cnt = free_cnt_q;
    assign stat_min_free = stat_min_free_q;
`endif

    // Protocol checks on the AFU and FIU-edge interfaces.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == ST_INIT) begin
                assert (!free_en)
                    else $fatal(1, "wr_heap: free_en during INIT");
            end
            if (sop_acc) begin
                assert (free_cnt_q != '0)
                    else $fatal(1, "wr_heap: SOP with empty free list");
                assert (beats_rem_q == 2'd0)
                    else $fatal(1, "wr_heap: SOP inside a packet");
                assert (afu_c1_cl_len != 2'd2)
                    else $fatal(1, "wr_heap: cl_len of 2 is illegal");
            end
            if (flit_acc && !afu_c1_sop) begin
                assert (beats_rem_q != 2'd0)
                    else $fatal(1, "wr_heap: data beat outside a packet");
            end
            if (state_q == ST_RUN && free_en) begin
                assert (free_cnt_q != N_CNT)
                    else $fatal(1, "wr_heap: free with full free list");
            end
        end
    end

endmodule

// File: tb/tb_cci_mpf_shim_edge_afu_wr_heap.sv
// Directed bench for cci_mpf_shim_edge_afu_wr_heap with N=8, threshold 2.
module tb_cci_mpf_shim_edge_afu_wr_heap;

    localparam int N     = 8;
    localparam int THR   = 2;
    localparam int HDR_W = 80;
    localparam int IDX_W = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              afu_c1_valid;
    logic              afu_c1_sop;
    logic [1:0]        afu_c1_cl_len;
    logic [HDR_W-1:0]  afu_c1_hdr;
    logic [511:0]      afu_c1_data;
    logic              afu_c1_almfull;
    logic              mpf_c1_valid;
    logic [HDR_W-1:0]  mpf_c1_hdr;
    logic [1:0]        mpf_c1_cl_len;
    logic [IDX_W-1:0]  mpf_c1_idx;
    logic              mpf_c1_almfull;
    logic              heap_wen;
    logic [IDX_W-1:0]  heap_widx;
    logic [1:0]        heap_wclnum;
    logic [511:0]      heap_wdata;
    logic              free_en;
    logic [IDX_W-1:0]  free_idx;

    int checks = 0;
    int errors = 0;
    int cyc;
    logic [511:0] dbeat [4];

    cci_mpf_shim_edge_afu_wr_heap #(
        .N_WRITE_HEAP_ENTRIES (N),
        .ALMFULL_THRESHOLD    (THR),
        .HDR_W                (HDR_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .afu_c1_valid   (afu_c1_valid),
        .afu_c1_sop     (afu_c1_sop),
        .afu_c1_cl_len  (afu_c1_cl_len),
        .afu_c1_hdr     (afu_c1_hdr),
        .afu_c1_data    (afu_c1_data),
        .afu_c1_almfull (afu_c1_almfull),
        .mpf_c1_valid   (mpf_c1_valid),
        .mpf_c1_hdr     (mpf_c1_hdr),
        .mpf_c1_cl_len  (mpf_c1_cl_len),
        .mpf_c1_idx     (mpf_c1_idx),
        .mpf_c1_almfull (mpf_c1_almfull),
        .heap_wen       (heap_wen),
        .heap_widx      (heap_widx),
        .heap_wclnum    (heap_wclnum),
        .heap_wdata     (heap_wdata),
        .free_en        (free_en),
        .free_idx       (free_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] got,
                       input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold reset 3 cycles, release, count cycles until almfull drops.
    task automatic reinit(output int n);
        afu_c1_valid = 1'b0;
        free_en      = 1'b0;
        reset        = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            n++;
            if (!afu_c1_almfull) break;
        end
    endtask

    // One single-beat packet; checks the request and heap write it produces.
    task automatic sop1(input logic [IDX_W-1:0] exp_idx, input string tag);
        logic [511:0] d;
        logic [HDR_W-1:0] h;
        d = {16{32'hC0DE_0000 | 32'(exp_idx)}};
        h = HDR_W'(64'h1234_5600 + 64'(exp_idx));
        afu_c1_valid  = 1'b1;
        afu_c1_sop    = 1'b1;
        afu_c1_cl_len = 2'd0;
        afu_c1_hdr    = h;
        afu_c1_data   = d;
        step();
        afu_c1_valid  = 1'b0;
        chk({tag, "_idx"}, 512'(mpf_c1_idx), 512'(exp_idx));
        chk({tag, "_vld"}, 512'(mpf_c1_valid & heap_wen), 512'(1));
        chk({tag, "_hdr"}, 512'(mpf_c1_hdr), 512'(h));
        chk({tag, "_widx"}, 512'({heap_widx, heap_wclnum}), 512'({exp_idx, 2'd0}));
        chk({tag, "_wdata"}, heap_wdata, d);
    endtask

    initial begin
        reset          = 1'b1;
        afu_c1_valid   = 1'b0;
        afu_c1_sop     = 1'b0;
        afu_c1_cl_len  = 2'd0;
        afu_c1_hdr     = '0;
        afu_c1_data    = '0;
        mpf_c1_almfull = 1'b0;
        free_en        = 1'b0;
        free_idx       = '0;
        for (int b = 0; b < 4; b++) dbeat[b] = {16{32'hDA7A_0000 + 32'(b)}};

        // Reset values and INIT duration
        repeat (3) step();
        chk("rst_almfull", 512'(afu_c1_almfull), 512'(1));
        chk("rst_mpf_valid", 512'(mpf_c1_valid), 512'(0));
        chk("rst_heap_wen", 512'(heap_wen), 512'(0));
        chk("rst_mpf_idx", 512'(mpf_c1_idx), 512'(0));
        chk("rst_wdata", heap_wdata, 512'(0));
        reset = 1'b0;
        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            cyc++;
            if (!afu_c1_almfull) break;
        end
        chk("init_len", 512'(cyc), 512'(8));

        sop1(3'd0, "a0");
        sop1(3'd1, "a1");
        step();
        chk("idle_mpf", 512'(mpf_c1_valid), 512'(0));
        chk("idle_wen", 512'(heap_wen), 512'(0));

        // Mid-stream upstream almfull
        mpf_c1_almfull = 1'b1;
        #1 chk("mpf_almfull", 512'(afu_c1_almfull), 512'(1));
        mpf_c1_almfull = 1'b0;
        #1 chk("mpf_almfull_off", 512'(afu_c1_almfull), 512'(0));

        // 4-beat packet takes index 2
        afu_c1_valid  = 1'b1;
        afu_c1_sop    = 1'b1;
        afu_c1_cl_len = 2'd3;
        afu_c1_hdr    = 80'hBEEF_0000_0000_0000_0004;
        afu_c1_data   = dbeat[0];
        step();
        chk("p4_mpf_vld", 512'(mpf_c1_valid), 512'(1));
        chk("p4_mpf_len", 512'(mpf_c1_cl_len), 512'(3));
        chk("p4_mpf_idx", 512'(mpf_c1_idx), 512'(2));
        chk("p4_hdr", 512'(mpf_c1_hdr), 512'(80'hBEEF_0000_0000_0000_0004));
        chk("p4_b0_wen", 512'(heap_wen), 512'(1));
        chk("p4_b0_addr", 512'({heap_widx, heap_wclnum}), 512'({3'd2, 2'd0}));
        chk("p4_b0_data", heap_wdata, dbeat[0]);
        for (int b = 1; b < 4; b++) begin
            afu_c1_sop  = 1'b0;
            afu_c1_data = dbeat[b];
            step();
            chk("p4_bN_mpf", 512'(mpf_c1_valid), 512'(0));
            chk("p4_bN_wen", 512'(heap_wen), 512'(1));
            chk("p4_bN_addr", 512'({heap_widx, heap_wclnum}), 512'({3'd2, 2'(b)}));
            chk("p4_bN_data", heap_wdata, dbeat[b]);
        end
        afu_c1_valid = 1'b0;
        step();
        chk("p4_end_wen", 512'(heap_wen), 512'(0));

        // Threshold crossing with no frees
        reinit(cyc);
        chk("reinit_len", 512'(cyc), 512'(8));
        for (int i = 0; i < 6; i++) begin
            sop1(3'(i), "thr");
            chk("thr_almfull", 512'(afu_c1_almfull), 512'(i == 5));
        end
        sop1(3'd6, "thr6");
        sop1(3'd7, "thr7");
        step();
        chk("empty_almfull", 512'(afu_c1_almfull), 512'(1));

        // Returned indices come back in FIFO order
        free_en  = 1'b1;
        free_idx = 3'd5;
        step();
        free_idx = 3'd2;
        step();
        free_en = 1'b0;
        sop1(3'd5, "fifo5");
        sop1(3'd2, "fifo2");

        // Free list of 3, then free and pop in the same cycle
        free_en = 1'b1;
        free_idx = 3'd0; step();
        free_idx = 3'd1; step();
        free_idx = 3'd4; step();
        free_en = 1'b0;
        chk("cnt3_almfull", 512'(afu_c1_almfull), 512'(0));
        free_en  = 1'b1;
        free_idx = 3'd7;
        sop1(3'd0, "simul");
        free_en = 1'b0;
        chk("simul_almfull", 512'(afu_c1_almfull), 512'(0));
        sop1(3'd1, "simul_n1");
        sop1(3'd4, "simul_n2");
        sop1(3'd7, "simul_n3");
        chk("simul_end_almfull", 512'(afu_c1_almfull), 512'(1));

        // Reset in the middle of a 4-beat packet
        reinit(cyc);
        sop1(3'd0, "mr0");
        afu_c1_valid  = 1'b1;
        afu_c1_sop    = 1'b1;
        afu_c1_cl_len = 2'd3;
        afu_c1_data   = dbeat[0];
        step();
        chk("mr_b0_idx", 512'(heap_widx), 512'(1));
        afu_c1_sop  = 1'b0;
        afu_c1_data = dbeat[1];
        step();
        chk("mr_b1_clnum", 512'(heap_wclnum), 512'(1));
        afu_c1_valid = 1'b0;
        reset        = 1'b1;
        step();
        chk("mr_wen", 512'(heap_wen), 512'(0));
        chk("mr_mpf_vld", 512'(mpf_c1_valid), 512'(0));
        chk("mr_mpf_out", 512'({mpf_c1_hdr, mpf_c1_cl_len, mpf_c1_idx}), 512'(0));
        chk("mr_almfull", 512'(afu_c1_almfull), 512'(1));
        reinit(cyc);
        chk("mr_init_len", 512'(cyc), 512'(8));
        sop1(3'd0, "mr_post");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
